// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: sequencing states.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_fulladder.sv
// Single-bit full adder cell used as the arithmetic core of the serial adder.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carryout
);

    assign sum      = a ^ b ^ c;
    assign carryout = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one fulladder, LSB first, one bit per clock,
// result and carry-out published together with a one-cycle done pulse.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_sh_reg, a_sh_next;
    logic [WIDTH-1:0] b_sh_reg, b_sh_next;
    logic [WIDTH-1:0] res_sh_reg, res_sh_next;
    logic             carry_reg, carry_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] sum_reg, sum_next;
    logic             cout_reg, cout_next;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] res_shifted;
    logic             load;

    fulladder u_fulladder (
        .a        (a_sh_reg[0]),
        .b        (b_sh_reg[0]),
        .c        (carry_reg),
        .sum      (fa_sum),
        .carryout (fa_cout)
    );

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    generate
        if (WIDTH == 1) begin : g_res_single
            assign res_shifted = fa_sum;
        end else begin : g_res_multi
            assign res_shifted = {fa_sum, res_sh_reg[WIDTH-1:1]};
        end
    endgenerate

    // A request is taken in IDLE and also in DONE (back-to-back issue).
    assign load = start && (state_reg != SHIFT);

    always_comb begin
        state_next  = state_reg;
        a_sh_next   = a_sh_reg;
        b_sh_next   = b_sh_reg;
        res_sh_next = res_sh_reg;
        carry_next  = carry_reg;
        cnt_next    = cnt_reg;
        sum_next    = sum_reg;
        cout_next   = cout_reg;

        case (state_reg)
            IDLE, DONE: begin
                state_next = IDLE;
                if (load) begin
                    state_next  = SHIFT;
                    a_sh_next   = a;
                    b_sh_next   = b;
                    res_sh_next = '0;
                    carry_next  = cin;
                    cnt_next    = '0;
                end
            end
            SHIFT: begin
                a_sh_next   = a_sh_reg >> 1;
                b_sh_next   = b_sh_reg >> 1;
                res_sh_next = res_shifted;
                carry_next  = fa_cout;
                cnt_next    = cnt_reg + CNT_W'(1);
                if (cnt_reg == LAST_BIT) begin
                    state_next = DONE;
                    sum_next   = res_shifted;
                    cout_next  = fa_cout;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            res_sh_reg <= '0;
            carry_reg  <= 1'b0;
            cnt_reg    <= '0;
            sum_reg    <= '0;
            cout_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            a_sh_reg   <= a_sh_next;
            b_sh_reg   <= b_sh_next;
            res_sh_reg <= res_sh_next;
            carry_reg  <= carry_next;
            cnt_reg    <= cnt_next;
            sum_reg    <= sum_next;
            cout_reg   <= cout_next;
        end
    end

    assign busy = (state_reg == SHIFT);
    assign done = (state_reg == DONE);
    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Randomised and directed checks of serial_adder (WIDTH=8 and WIDTH=1)
// against plain a+b+cin arithmetic.
module tb_serial_adder;

    logic       clk;
    logic       rst;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;

    logic       start1, cin1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;

    int         checks;
    int         errors;
    logic [8:0] held;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a request for one edge on the 8-bit instance.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic c);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    endtask

    // Waits for done, checking busy and the held result on every cycle before it.
    task automatic wait_done(input int cyc0, output int cyc);
        int hold_err;
        int busy_lo;
        hold_err = 0;
        busy_lo  = 0;
        cyc      = cyc0;
        while (!done8 && cyc < 40) begin
            if ({cout8, sum8} !== held) hold_err++;
            if (busy8 !== 1'b1) busy_lo++;
            tick();
            cyc++;
        end
        check("hold_while_busy", 64'(hold_err), 64'd0);
        check("busy_throughout", 64'(busy_lo), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c);
        logic [8:0] exp;
        int cyc;
        exp = 9'(a) + 9'(b) + 9'(c);
        start_op(a, b, c);
        wait_done(0, cyc);
        check({tag, "_latency"}, 64'(cyc), 64'd8);
        check({tag, "_busy_in_done"}, 64'(busy8), 64'd0);
        check({tag, "_result"}, 64'({cout8, sum8}), 64'(exp));
        held = exp;
    endtask

    // Counts done pulses and busy cycles over a quiet window.
    task automatic quiet(input string tag, input int n);
        int extra;
        extra = 0;
        for (int i = 0; i < n; i++) begin
            if (done8 || busy8) extra++;
            tick();
        end
        check(tag, 64'(extra), 64'd0);
    endtask

    initial begin
        int cyc;
        logic [1:0] exp1;
        checks = 0; errors = 0; held = '0;
        rst = 1'b1;
        start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
        start1 = 0; a1 = 0; b1 = 0; cin1 = 0;
        tick(); tick();
        rst = 1'b0;
        check("reset_state8", 64'({busy8, done8, cout8, sum8}), 64'd0);
        check("reset_state1", 64'({busy1, done1, cout1, sum1}), 64'd0);

        // Directed arithmetic
        run_op("basic", 8'h5A, 8'h3C, 1'b0);
        tick();
        check("done_one_cycle", 64'({done8, busy8}), 64'd0);
        run_op("carry_ff_01", 8'hFF, 8'h01, 1'b0);
        tick();
        run_op("carry_ff_ff_1", 8'hFF, 8'hFF, 1'b1);
        tick();
        run_op("zero", 8'h00, 8'h00, 1'b0);
        tick();

        // Randomised operands, some issued back-to-back from the DONE cycle
        for (int i = 0; i < 16; i++) begin
            run_op($sformatf("rand%0d", i), 8'($urandom), 8'($urandom), 1'($urandom));
            if ($urandom_range(1, 0) == 1) tick();
        end
        tick();

        // Start while busy is ignored
        start_op(8'h10, 8'h20, 1'b0);
        tick(); tick(); tick();
        a8 = 8'hAA; b8 = 8'hAA; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        wait_done(4, cyc);
        check("ignored_latency", 64'(cyc), 64'd8);
        check("ignored_result", 64'({cout8, sum8}), 64'h030);
        held = 9'h030;
        tick();
        quiet("ignored_no_second_op", 12);

        // Back-to-back: second request lands in the DONE cycle of the first
        run_op("b2b_first", 8'h33, 8'h44, 1'b0);
        run_op("b2b_second", 8'h01, 8'h02, 1'b1);
        tick();

        // Reset during the 4th SHIFT cycle aborts silently
        start_op(8'h11, 8'h22, 1'b0);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midreset_outputs", 64'({busy8, done8, cout8, sum8}), 64'd0);
        held = '0;
        quiet("midreset_no_done", 12);
        run_op("after_reset", 8'h7F, 8'h01, 1'b0);
        tick();

        // WIDTH=1 instance: all eight operand combinations
        for (int v = 7; v >= 0; v--) begin
            a1 = 1'(v >> 2); b1 = 1'(v >> 1); cin1 = 1'(v);
            exp1 = 2'(a1) + 2'(b1) + 2'(cin1);
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            a1 = ~a1; b1 = ~b1; cin1 = ~cin1;
            check($sformatf("w1_busy_%0d", v), 64'({busy1, done1}), 64'h2);
            tick();
            check($sformatf("w1_done_%0d", v), 64'({busy1, done1}), 64'h1);
            check($sformatf("w1_result_%0d", v), 64'({cout1, sum1}), 64'(exp1));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
